valu_arbiter: RTL and testbench
===============================

Name: valu_arbiter

Overview:
- Shares one combinational vector ALU instance between two requesters, e.g. the scalar-issue pipeline and the alpha-compositing DMA/unpack engine.
- Each requester has a valid/ready channel; grants use round-robin.
- Drives the ALU operands and selector, captures the result into a single registered response slot tagged with requester id, and stalls under response back-pressure.

Parameters:
N, 128, vector width in bits; matches the ALU operand/result width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  3  ALU selector (0 zero, 1 pass A, 2 add, 3 sub, 4 mul, 5 div, 6/7 reserved)
req0_a  in  N  operand A
req0_b  in  N  operand B
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 accepted
req1_op  in  3  as req0_op
req1_a  in  N  operand A
req1_b  in  N  operand B
alu_a  out  N  ALU operand A
alu_b  out  N  ALU operand B
alu_sel  out  3  ALU selector
alu_c  in  N  ALU result (combinational from alu_a/alu_b/alu_sel)
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that issued the response
rsp_data  out  N  captured ALU result
rsp_err  out  1  op was reserved (6/7)

Behaviour:
- Reset, synchronous, rst=1 at a clock edge:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, last_grant=1, so requester 0 wins first.
  - A response pending at reset is discarded.
  - reqX_ready=0 while rst=1.
- can_accept = !rsp_valid || rsp_ready (combinational).
- Grant, combinational, evaluated every cycle:
  - only reqX_valid high -> grant X;
  - both high -> grant !last_grant;
  - none -> no grant.
- reqX_ready = can_accept && grant==X. At most one ready is high per cycle.
- ALU drive:
  - With a grant, alu_a/alu_b/alu_sel = granted req_a/req_b/req_op, regardless of can_accept.
  - With no grant, all three are 0.
- Handshake (reqX_valid && reqX_ready) at an edge:
  - rsp_data<=alu_c, rsp_id<=X, rsp_err<=(op>=6), rsp_valid<=1, last_grant<=X.
  - Latency: request accepted in cycle T -> rsp_valid=1 in cycle T+1.
- Drain without new accept (rsp_valid && rsp_ready, no handshake) -> rsp_valid<=0. rsp_data/id/err hold their last values.
- Simultaneous drain and accept in the same cycle -> the slot is overwritten with the new result and rsp_valid stays 1. Full throughput is one op per cycle.
- Back-pressure: while rsp_valid && !rsp_ready, both readies are 0 and rsp_data/id/err/valid stay stable.
- last_grant changes only on a handshake. A requester that drops valid before being served loses nothing.
- Reserved ops 6/7 are still executed, producing the ALU zero result, and reported with rsp_err=1. Op 0 is legal and has rsp_err=0.
- Requesters must hold valid/op/a/b stable until ready. The block does not check this.
- Requester valid is not required to depend on ready; no combinational path from rsp_ready to reqX_valid is assumed.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with both req valid.
  - Required: rsp_valid=0, both ready=0, rsp_data=0.
  - After release with both valid: req0_ready=1 first cycle, req1_ready=0.
- Single pass-through:
  - Stimulus: req0 op=1, a=128'h0102...0F10, rsp_ready=1.
  - Required: alu_sel=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=128'h0102...0F10, rsp_err=0.
- Round-robin fairness:
  - Stimulus: both valid continuously, rsp_ready=1, req0 op=1 a=A0, req1 op=1 a=A1.
  - Required: responses alternate id 0,1,0,1 with data A0,A1,A0,A1, one per cycle.
- Back-pressure:
  - Stimulus: req1 op=2 accepted, then rsp_ready=0 for 3 cycles with req0 valid.
  - Required: rsp_data equals the alu_c sampled at accept and holds; req0_ready=0 for 3 cycles; req0 accepted in the cycle rsp_ready returns to 1, with its response in the following cycle.
- Reserved op:
  - Stimulus: req0 op=7, a=b=all-ones.
  - Required: rsp_err=1, rsp_data=0, rsp_id=0. Then op=0 gives rsp_err=0.
- Reset mid-operation:
  - Stimulus: response pending with rsp_ready=0, assert rst 1 cycle.
  - Required: rsp_valid=0 next cycle; next grant goes to req0 when both valid.

Source files
------------

// File: rtl/valu_arbiter.sv
// valu_arbiter: round-robin sharing of one combinational vector ALU between two requesters with a registered response slot
module valu_arbiter #(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [N-1:0] alu_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err
);
  logic last_grant;
  logic can_accept;
  logic gnt_any;
  logic gnt;
  logic accept;
  always_comb begin
    can_accept = !rsp_valid || rsp_ready;
    gnt_any    = req0_valid || req1_valid;
    gnt        = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    req0_ready = !rst && can_accept && gnt_any && !gnt;
    req1_ready = !rst && can_accept && gnt_any && gnt;
    accept     = req0_ready || req1_ready;
    alu_a      = gnt_any ? (gnt ? req1_a : req0_a) : '0;
    alu_b      = gnt_any ? (gnt ? req1_b : req0_b) : '0;
    alu_sel    = gnt_any ? (gnt ? req1_op : req0_op) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= alu_c;
      rsp_id     <= gnt;
      rsp_err    <= alu_sel[2] && alu_sel[1];
      last_grant <= gnt;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_valu_arbiter.sv
// tb_valu_arbiter: directed and randomized checks of valu_arbiter against a behavioural model
module tb_valu_arbiter;
  localparam int N = 128;
  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [N-1:0] alu_a, alu_b, alu_c;
  logic [2:0]   alu_sel;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [N-1:0] rsp_data;
  int checks = 0;
  int errors = 0;
  logic         m_valid, m_id, m_err, m_last;
  logic [N-1:0] m_data;
  logic         acc0, acc1;
  always #5 clk = ~clk;
  valu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  function automatic logic [N-1:0] alu_f(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    case (op)
      3'd1: return a;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return a * b;
      3'd5: return (b == '0) ? '0 : a / b;
      default: return '0;
    endcase
  endfunction
  always_comb alu_c = alu_f(alu_sel, alu_a, alu_b);
  function automatic logic [N-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // which requester the model expects to be served: the one not served last, when both ask
  function automatic int winner();
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction
  function automatic logic [1:0] exp_rdy();
    int w;
    w = winner();
    if (rst || (m_valid && !rsp_ready) || w < 0) return 2'b00;
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction
  task automatic drive(input logic v0, input logic [2:0] o0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                       input logic v1, input logic [2:0] o1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                       input logic rr);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready = rr;
    #1;
  endtask
  task automatic tick();
    logic [1:0] r;
    logic [2:0] op;
    r = exp_rdy();
    op = r[1] ? req1_op : req0_op;
    acc0 = r[0];
    acc1 = r[1];
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_last = 1;
    end else if (r != 2'b00) begin
      m_valid = 1;
      m_id = r[1];
      m_err = (op >= 3'd6);
      m_data = r[1] ? alu_f(req1_op, req1_a, req1_b) : alu_f(req0_op, req0_a, req0_b);
      m_last = r[1];
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    drive(1, 3'd1, rnd(), rnd(), 1, 3'd1, rnd(), rnd(), 1);
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {req1_ready, req0_ready}); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", rsp_data); end
    rst = 0;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", {req1_ready, req0_ready}); end
  endtask
  task automatic test_pass();
    logic [N-1:0] a;
    a = 128'h0102030405060708090A0B0C0D0E0F10;
    drive(1, 3'd1, a, rnd(), 0, 3'd0, '0, '0, 1);
    checks++; if (alu_sel !== 3'd1 || alu_a !== a) begin errors++; $display("FAIL pass_drive got sel %0d a %h want 1 %h", alu_sel, alu_a, a); end
    tick();
    checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b100) begin errors++; $display("FAIL pass_rsp got v/id/err %b want 100", {rsp_valid, rsp_id, rsp_err}); end
    checks++; if (rsp_data !== a) begin errors++; $display("FAIL pass_data got %h want %h", rsp_data, a); end
  endtask
  task automatic test_round_robin();
    logic [N-1:0] a0, a1;
    a0 = rnd();
    a1 = rnd();
    rst = 1;
    drive(0, 3'd0, '0, '0, 0, 3'd0, '0, '0, 1);
    tick();
    rst = 0;
    drive(1, 3'd1, a0, rnd(), 1, 3'd1, a1, rnd(), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== i[0] || rsp_data !== (i[0] ? a1 : a0)) begin
        errors++;
        $display("FAIL rr_%0d got v %b id %b data %h want 1 %b %h", i, rsp_valid, rsp_id, rsp_data, i[0], i[0] ? a1 : a0);
      end
    end
  endtask
  task automatic test_backpressure();
    logic [N-1:0] a, b, x, sum;
    a = rnd(); b = rnd(); x = rnd();
    sum = a + b;
    drive(0, 3'd0, '0, '0, 1, 3'd2, a, b, 1);
    tick();
    drive(1, 3'd1, x, rnd(), 0, 3'd0, '0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got %b want 0", i, req0_ready); end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== sum) begin
        errors++;
        $display("FAIL bp_hold_%0d got v %b id %b data %h want 1 1 %h", i, rsp_valid, rsp_id, rsp_data, sum);
      end
    end
    rsp_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", req0_ready); end
    tick();
    checks++; if (rsp_id !== 1'b0 || rsp_data !== x) begin errors++; $display("FAIL bp_next got id %b data %h want 0 %h", rsp_id, rsp_data, x); end
  endtask
  task automatic test_reserved();
    drive(1, 3'd7, '1, '1, 0, 3'd0, '0, '0, 1);
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_id} !== 3'b110 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reserved got v/err/id %b data %h want 110 0", {rsp_valid, rsp_err, rsp_id}, rsp_data);
    end
    drive(1, 3'd0, '1, '1, 0, 3'd0, '0, '0, 1);
    tick();
    checks++; if (rsp_err !== 1'b0 || rsp_data !== '0) begin errors++; $display("FAIL op_zero got err %b data %h want 0 0", rsp_err, rsp_data); end
  endtask
  task automatic test_reset_mid();
    drive(1, 3'd1, rnd(), rnd(), 0, 3'd0, '0, '0, 1);
    tick();
    drive(0, 3'd0, '0, '0, 0, 3'd0, '0, '0, 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", rsp_valid); end
    drive(1, 3'd1, rnd(), rnd(), 1, 3'd1, rnd(), rnd(), 0);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL mid_reset_grant got %b want 01", {req1_ready, req0_ready}); end
  endtask
  task automatic test_random();
    logic [1:0] er;
    int w;
    logic [2:0] esel;
    logic [N-1:0] ea;
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op = 3'($urandom_range(0, 7)); req0_a = rnd(); req0_b = {96'd0, $urandom};
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op = 3'($urandom_range(0, 7)); req1_a = rnd(); req1_b = {96'd0, $urandom};
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_rdy();
      w = winner();
      esel = (w < 0) ? 3'd0 : (w == 1) ? req1_op : req0_op;
      ea = (w < 0) ? '0 : (w == 1) ? req1_a : req0_a;
      checks++; if ({req1_ready, req0_ready} !== er) begin errors++; $display("FAIL rnd_ready_%0d got %b want %b", i, {req1_ready, req0_ready}, er); end
      checks++; if (alu_sel !== esel || alu_a !== ea) begin errors++; $display("FAIL rnd_alu_%0d got sel %0d a %h want %0d %h", i, alu_sel, alu_a, esel, ea); end
      tick();
      checks++;
      if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_err !== m_err || rsp_data !== m_data) begin
        errors++;
        $display("FAIL rnd_rsp_%0d got v%b id%b e%b %h want v%b id%b e%b %h", i, rsp_valid, rsp_id, rsp_err, rsp_data, m_valid, m_id, m_err, m_data);
      end
    end
  endtask
  initial begin
    rst = 1;
    acc0 = 0; acc1 = 0;
    m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_last = 1;
    drive(0, 3'd0, '0, '0, 0, 3'd0, '0, '0, 1);
    test_reset();
    test_pass();
    test_round_robin();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
